threshold_ctrl: RTL
===================

Name: threshold_ctrl

Overview:
- Configuration and statistics controller for the YCbCr chroma-window binarisation datapath.
- Holds four window thresholds in a shadow register bank, written over a valid/ready config port.
- Commits shadow to live thresholds only at a frame boundary (vsync active edge), so the window never changes mid-frame.
- Counts foreground (mask=1) pixels per frame and reports the count once per frame.
- Sits between the control source (switches/UART/soft CPU) and the thresholding stage in the HDMI pipeline.

Parameters:
- TA_INIT, 90, reset value of Cr lower bound (exclusive)
- TB_INIT, 200, reset value of Cr upper bound (exclusive)
- TC_INIT, 90, reset value of Cb lower bound (exclusive)
- TD_INIT, 200, reset value of Cb upper bound (exclusive)
- VS_ACTIVE_HIGH, 1, 1 = vsync active level is high; 0 = active low
- CNT_W, 22, width of the foreground pixel counter

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_addr  in  2  0=ta, 1=tb, 2=tc, 3=td
- cfg_data  in  8  threshold value
- hdmi_vs_in  in  1  vertical sync from the pipeline
- de_in  in  1  data enable aligned with mask_in
- mask_in  in  1  binarised pixel from the thresholding stage
- ta, tb, tc, td  out  8 each  live thresholds to the datapath
- cfg_pending  out  1  shadow differs from live (write awaiting commit)
- fg_count  out  CNT_W  foreground pixel count of the last complete frame
- fg_valid  out  1  one-cycle pulse when fg_count updates
- frame_cnt  out  16  completed frames since reset, wraps at 65535->0

Behaviour:
- Reset (async, rst_n=0):
  - shadow and live thresholds = *_INIT
  - state IDLE; cfg_pending=0, fg_count=0, fg_valid=0, frame_cnt=0
  - internal accumulator=0, first_frame flag=1
  - vs_d = inactive level
- Frame edge: vs_d registers hdmi_vs_in each cycle. vs_edge = (hdmi_vs_in==active) & (vs_d!=active), evaluated in the same cycle.
- FSM states: IDLE, PENDING, COMMIT.
  - IDLE -> PENDING on an accepted write.
  - PENDING -> COMMIT on vs_edge.
  - COMMIT -> IDLE after exactly one cycle.
  - IDLE ignores vs_edge for commit purposes; statistics still run.
- Config handshake:
  - cfg_ready=1 in IDLE and PENDING, 0 in COMMIT.
  - On valid&ready, shadow[cfg_addr] <= cfg_data at the clock edge.
  - Multiple writes per frame are allowed; last write to an address wins.
  - A write accepted in the same cycle as vs_edge is included in that commit.
- Commit:
  - In COMMIT, live <= shadow (all four at once).
  - The new thresholds are visible 2 cycles after the vs_edge cycle.
  - cfg_pending=1 in PENDING and COMMIT, 0 in IDLE (registered with state).
- Values are not checked. ta>=tb or tc>=td is committed as written; the datapath then yields all-zero masks.
- Statistics:
  - Accumulator += 1 when de_in & mask_in; saturates at 2^CNT_W-1.
  - On vs_edge: if first_frame=0, then fg_count <= accumulator (including a pixel counted in that cycle), fg_valid pulses next cycle, and frame_cnt increments.
  - On every vs_edge: accumulator restarts (at 1 if that cycle's pixel counts, else 0) and first_frame <= 0.
  - The partial frame after reset is therefore never reported.
- Reset mid-commit or mid-frame: immediate return to reset values; no partial commit persists.

Decomposition:
- Shared package holds:
  - cfg address constants (ADDR_TA..ADDR_TD)
  - FSM state encoding
  - default threshold constants, reused by the thresholding stage
- One natural sub-module: frame_stats (vs edge detect, saturating accumulator, fg_count/fg_valid/frame_cnt). The threshold FSM and register bank stay in threshold_ctrl.

Test Plan:
- Reset: release rst_n -> ta=90, tb=200, tc=90, td=200; cfg_ready=1; cfg_pending=0; fg_valid stays 0 through the first vs_edge.
- Deferred commit:
  - Write addr0=100 mid-frame -> ta stays 90 and cfg_pending=1.
  - vs_edge at cycle N -> ta=100 from cycle N+2; cfg_pending=0 from N+2.
- Edge-coincident write: write addr3=180 in the vs_edge cycle -> included in the commit; td=180 at N+2. cfg_ready=0 at N+1; a write held through N+1 is accepted at N+2 and leaves cfg_pending=1.
- Statistics:
  - Frame 1 (partial) -> no report.
  - Frame 2 with 1000 de cycles, 250 with mask_in=1 -> fg_valid pulse one cycle after edge, fg_count=250, frame_cnt=1.
  - Pixels with de_in=0 and mask_in=1 are not counted.
- Saturation: CNT_W=4, 20 foreground pixels in one frame -> fg_count=15.
- Async reset during PENDING: shadow ta=50, assert rst_n=0 before the edge -> ta=90, cfg_pending=0, and the next vs_edge commits nothing.

Source files
------------

// File: rtl/threshold_ctrl_pkg.sv
// Shared constants and types for the chroma-window threshold controller
// and the thresholding stage that consumes its live thresholds.
package threshold_ctrl_pkg;

    localparam logic [1:0] ADDR_TA = 2'd0;
    localparam logic [1:0] ADDR_TB = 2'd1;
    localparam logic [1:0] ADDR_TC = 2'd2;
    localparam logic [1:0] ADDR_TD = 2'd3;

    localparam logic [7:0] TA_DEF = 8'd90;
    localparam logic [7:0] TB_DEF = 8'd200;
    localparam logic [7:0] TC_DEF = 8'd90;
    localparam logic [7:0] TD_DEF = 8'd200;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] ta;
        logic [7:0] tb;
        logic [7:0] tc;
        logic [7:0] td;
    } thr_t;

endpackage

// File: rtl/threshold_ctrl_if.sv
// Threshold configuration write port (valid/ready, one byte per address).
interface threshold_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/threshold_ctrl_frame_stats.sv
// Frame-edge detection and per-frame foreground pixel statistics.
module threshold_ctrl_frame_stats #(
    parameter bit VS_ACTIVE_HIGH = 1'b1,
    parameter int CNT_W          = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hdmi_vs_in,
    input  logic             de_in,
    input  logic             mask_in,
    output logic             vs_edge,
    output logic [CNT_W-1:0] fg_count,
    output logic             fg_valid,
    output logic [15:0]      frame_cnt
);

    logic             vs_dly_q, vs_dly_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
    logic [CNT_W-1:0] fg_count_q, fg_count_d;
    logic             fg_valid_q, fg_valid_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             pix;

    assign vs_edge = (hdmi_vs_in == VS_ACTIVE_HIGH) && (vs_dly_q != VS_ACTIVE_HIGH);

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        vs_dly_d    = hdmi_vs_in;
        pix         = de_in & mask_in;
        acc_inc     = (pix && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;
        acc_d       = acc_inc;
        first_d     = first_q;
        fg_count_d  = fg_count_q;
        fg_valid_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (vs_edge) begin
            // The edge-cycle pixel closes the old frame; the new frame restarts from it.
            acc_d   = pix ? CNT_W'(1) : '0;
            first_d = 1'b0;
            if (!first_q) begin
                fg_count_d  = acc_inc;
                fg_valid_d  = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_dly_q    <= ~VS_ACTIVE_HIGH;
            first_q     <= 1'b1;
            acc_q       <= '0;
            fg_count_q  <= '0;
            fg_valid_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vs_dly_q    <= vs_dly_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            fg_count_q  <= fg_count_d;
            fg_valid_q  <= fg_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign fg_count  = fg_count_q;
    assign fg_valid  = fg_valid_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: rtl/threshold_ctrl.sv
// Shadow/live chroma-window threshold bank with frame-aligned commit,
// plus per-frame foreground statistics.
module threshold_ctrl
    import threshold_ctrl_pkg::*;
#(
    parameter logic [7:0] TA_INIT        = TA_DEF,
    parameter logic [7:0] TB_INIT        = TB_DEF,
    parameter logic [7:0] TC_INIT        = TC_DEF,
    parameter logic [7:0] TD_INIT        = TD_DEF,
    parameter bit         VS_ACTIVE_HIGH = 1'b1,
    parameter int         CNT_W          = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    threshold_ctrl_if.slave      cfg,
    input  logic                 hdmi_vs_in,
    input  logic                 de_in,
    input  logic                 mask_in,
    output logic [7:0]           ta,
    output logic [7:0]           tb,
    output logic [7:0]           tc,
    output logic [7:0]           td,
    output logic                 cfg_pending,
    output logic [CNT_W-1:0]     fg_count,
    output logic                 fg_valid,
    output logic [15:0]          frame_cnt
);

    localparam thr_t THR_INIT = '{ta: TA_INIT, tb: TB_INIT, tc: TC_INIT, td: TD_INIT};

    state_e state_q, state_d;
    thr_t   shadow_q, shadow_d;
    thr_t   live_q, live_d;
    logic   cfg_pending_q, cfg_pending_d;
    logic   wr_en;
    logic   vs_edge;

    threshold_ctrl_frame_stats #(
        .VS_ACTIVE_HIGH (VS_ACTIVE_HIGH),
        .CNT_W          (CNT_W)
    ) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .hdmi_vs_in (hdmi_vs_in),
        .de_in      (de_in),
        .mask_in    (mask_in),
        .vs_edge    (vs_edge),
        .fg_count   (fg_count),
        .fg_valid   (fg_valid),
        .frame_cnt  (frame_cnt)
    );

    assign cfg.cfg_ready = (state_q != COMMIT);
    assign wr_en         = cfg.cfg_valid & cfg.cfg_ready;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        live_d   = live_q;
        if (wr_en) begin
            case (cfg.cfg_addr)
                ADDR_TA: shadow_d.ta = cfg.cfg_data;
                ADDR_TB: shadow_d.tb = cfg.cfg_data;
                ADDR_TC: shadow_d.tc = cfg.cfg_data;
                ADDR_TD: shadow_d.td = cfg.cfg_data;
            endcase
        end
        case (state_q)
            IDLE:    if (wr_en) state_d = PENDING;
            PENDING: if (vs_edge) state_d = COMMIT;
            COMMIT: begin
                // Shadow already holds any write accepted in the edge cycle.
                live_d  = shadow_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cfg_pending_d = (state_d != IDLE);
    end

    // NOTE: the small threshold bank is reset explicitly, so thresholds are
    // defined from the first frame and a reset always discards a pending commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shadow_q      <= THR_INIT;
            live_q        <= THR_INIT;
            cfg_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            live_q        <= live_d;
            cfg_pending_q <= cfg_pending_d;
        end
    end

    assign ta          = live_q.ta;
    assign tb          = live_q.tb;
    assign tc          = live_q.tc;
    assign td          = live_q.td;
    assign cfg_pending = cfg_pending_q;

endmodule
